// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: flow-controlled pipeline stage register with a one-word skid.
// Holds up to two words (main + skid). in_ready is decoded purely from the
// registered state, so a downstream stall never reaches upstream combinationally.
// All state updates occur on the falling edge of clk; reset is asynchronous.
module pipe_stage_reg #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  // State encoding equals the occupancy, so count is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_nxt;
  logic [WIDTH-1:0] main_q, main_nxt;
  logic [WIDTH-1:0] skid_q, skid_nxt;
  logic             in_xfer;
  logic             out_xfer;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign count     = state_q;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // Next-state and data-register steering; flush clears validity only.
  always_comb begin
    state_nxt = state_q;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_nxt = ONE;
            main_nxt  = in_data;
          end
        end
        ONE: begin
          unique case ({in_xfer, out_xfer})
            2'b11: main_nxt = in_data;
            2'b10: begin
              state_nxt = FULL;
              skid_nxt  = in_data;
            end
            2'b01: state_nxt = EMPTY;
            default: ;
          endcase
        end
        FULL: begin
          if (out_xfer) begin
            state_nxt = ONE;
            main_nxt  = skid_q;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Occupancy state register.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_nxt;
  end

  // Main and skid data registers.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      main_q <= RESET_VALUE;
      skid_q <= RESET_VALUE;
    end else begin
      main_q <= main_nxt;
      skid_q <= skid_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed vector table plus hand-written corner sequences
// and a queue reference model for arrival ordering.
module tb_pipe_stage_reg;

  logic        clk;
  logic        reset;
  logic        flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [1:0]  count;

  logic        flush8, in_valid8, out_ready8;
  logic [7:0]  in_data8;
  logic        in_ready8, out_valid8;
  logic [7:0]  out_data8;
  logic [1:0]  count8;

  int unsigned n_checks;
  int unsigned n_fail;

  pipe_stage_reg #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  pipe_stage_reg #(.WIDTH(8), .RESET_VALUE(8'hFF)) dut8 (
    .clk(clk), .reset(reset), .flush(flush8),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .count(count8)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        fl;
    logic        ev;
    logic [31:0] ed;
    logic [1:0]  ec;
    logic        eir;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(logic iv, logic [31:0] d, logic o, logic f,
                              logic ev, logic [31:0] ed, logic [1:0] ec, logic eir);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = o; v.fl = f;
    v.ev = ev; v.ed = ed; v.ec = ec; v.eir = eir;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Active edge is negedge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  logic [31:0] q[$];
  logic        acc, pop;

  initial begin
    n_checks = 0; n_fail = 0;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    flush8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b0; in_data8 = '0;
    reset = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count",     32'(count),     32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_data",  out_data,       32'h0);
    check("rst8_out_data", 32'(out_data8), 32'hFF);
    #1 reset = 1'b0;
    @(negedge clk); #1;

    //             iv    data    ordy  fl    ev    exp data ec     eir
    tbl[0]  = mk(1'b1, 32'h11, 1'b1, 1'b0, 1'b1, 32'h11, 2'd1, 1'b1);
    tbl[1]  = mk(1'b1, 32'h22, 1'b1, 1'b0, 1'b1, 32'h22, 2'd1, 1'b1);
    tbl[2]  = mk(1'b1, 32'h33, 1'b1, 1'b0, 1'b1, 32'h33, 2'd1, 1'b1);
    tbl[3]  = mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h33, 2'd0, 1'b1);
    tbl[4]  = mk(1'b1, 32'hA1, 1'b0, 1'b0, 1'b1, 32'hA1, 2'd1, 1'b1);
    tbl[5]  = mk(1'b1, 32'hA2, 1'b0, 1'b0, 1'b1, 32'hA1, 2'd2, 1'b0);
    tbl[6]  = mk(1'b1, 32'hA3, 1'b0, 1'b0, 1'b1, 32'hA1, 2'd2, 1'b0);
    tbl[7]  = mk(1'b1, 32'hA3, 1'b1, 1'b0, 1'b1, 32'hA2, 2'd1, 1'b1);
    tbl[8]  = mk(1'b1, 32'hA3, 1'b1, 1'b0, 1'b1, 32'hA3, 2'd1, 1'b1);
    tbl[9]  = mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'hA3, 2'd0, 1'b1);
    tbl[10] = mk(1'b1, 32'h55, 1'b0, 1'b0, 1'b1, 32'h55, 2'd1, 1'b1);
    tbl[11] = mk(1'b1, 32'h66, 1'b0, 1'b1, 1'b0, 32'h55, 2'd0, 1'b1);
    tbl[12] = mk(1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h55, 2'd0, 1'b1);
    tbl[13] = mk(1'b1, 32'h01, 1'b0, 1'b0, 1'b1, 32'h01, 2'd1, 1'b1);
    tbl[14] = mk(1'b1, 32'h02, 1'b0, 1'b0, 1'b1, 32'h01, 2'd2, 1'b0);
    tbl[15] = mk(1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h01, 2'd0, 1'b1);
    tbl[16] = mk(1'b1, 32'h77, 1'b0, 1'b0, 1'b1, 32'h77, 2'd1, 1'b1);

    for (int unsigned i = 0; i < 17; i++) begin
      in_valid = tbl[i].iv; in_data = tbl[i].d;
      out_ready = tbl[i].ordy; flush = tbl[i].fl;
      step();
      check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      check($sformatf("v%0d_out_data", i),  out_data,       tbl[i].ed);
      check($sformatf("v%0d_count", i),     32'(count),     32'(tbl[i].ec));
      check($sformatf("v%0d_in_ready", i),  32'(in_ready),  32'(tbl[i].eir));
    end
    flush = 1'b0;

    // 8-bit instance: stream 0x00, 0x80, 0xFF with out_ready high.
    out_ready8 = 1'b1; in_valid8 = 1'b1;
    in_data8 = 8'h00; step();
    check("w8_d00", 32'(out_data8), 32'h00);
    check("w8_cnt_a", 32'(count8), 32'd1);
    in_data8 = 8'h80; step();
    check("w8_d80", 32'(out_data8), 32'h80);
    in_data8 = 8'hFF; step();
    check("w8_dFF", 32'(out_data8), 32'hFF);
    check("w8_valid", 32'(out_valid8), 32'd1);
    in_valid8 = 1'b0; step();
    check("w8_cnt_end", 32'(count8), 32'd0);

    // Fill to FULL, then assert reset between clock edges.
    in_valid = 1'b1; in_data = 32'h88; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check("pre_rst_count", 32'(count), 32'd2);
    #2 reset = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_count",     32'(count),     32'd0);
    check("async_rst_in_ready",  32'(in_ready),  32'd1);
    check("async_rst_out_data",  out_data,       32'h0);
    check("async_rst8_out_data", 32'(out_data8), 32'hFF);
    reset = 1'b0;
    step();

    // Random traffic against a FIFO model to confirm ordering and occupancy.
    for (int unsigned i = 0; i < 80; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      acc = in_valid && (q.size() < 2);
      pop = out_ready && (q.size() != 0);
      step();
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(in_data);
      check("sb_out_valid", 32'(out_valid), 32'(q.size() != 0));
      check("sb_count",     32'(count),     32'(q.size()));
      if (q.size() != 0) check("sb_out_data", out_data, q[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
